// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: opcodes and FSM state encoding.
package alu_pkg;
  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_DEC = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_INC = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_arbiter_alu.sv
// 8-op combinational ALU; overflow is signed, taken from bit WIDTH-1, and 0 for logic ops.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] o,
  output logic             of
);
  localparam int MSB = WIDTH - 1;

  always_comb begin
    o  = '0;
    of = 1'b0;
    case (op)
      OP_NOT: o = ~a;
      OP_AND: o = a & b;
      OP_XOR: o = a ^ b;
      OP_OR:  o = a | b;
      OP_DEC: begin
        o  = a - 1'b1;
        of = a[MSB] & ~o[MSB];
      end
      OP_ADD: begin
        o  = a + b;
        of = (a[MSB] == b[MSB]) && (o[MSB] != a[MSB]);
      end
      OP_SUB: begin
        o  = a - b;
        of = (a[MSB] != b[MSB]) && (o[MSB] != a[MSB]);
      end
      default: begin
        o  = a + 1'b1;
        of = ~a[MSB] & o[MSB];
      end
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters, one op in flight.
// Optional sticky overflow status enabled by ALU_ARB_OVF_STICKY_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_v,
  output logic [1:0]       req_rdy,
  input  logic [2:0]       req_op0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             rsp_v,
  input  logic             rsp_rdy,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_o,
  output logic             rsp_of,
  input  logic             ovf_clr,
  output logic [1:0]       ovf_stat,
  output logic             ovf_irq
);
  function automatic logic [1:0] rr_grant(input logic [1:0] v, input logic last);
    case (v)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return last ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  state_t           state;
  logic             last;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [WIDTH-1:0] alu_o;
  logic             alu_of;
  logic             can_grant, accept, win;

  // RESP can hand off to a new request in the same cycle the response drains
  assign can_grant = (state == IDLE) || (state == RESP && rsp_rdy);
  assign req_rdy   = (rst_n && can_grant) ? rr_grant(req_v, last) : 2'b00;
  assign accept    = |req_rdy;
  assign win       = req_rdy[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
      last <= 1'b1;
    end else if (accept) begin
      op_q <= win ? req_op1 : req_op0;
      a_q  <= win ? req_a1  : req_a0;
      b_q  <= win ? req_b1  : req_b0;
      id_q <= win;
      last <= win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rsp_v  <= 1'b0;
      rsp_id <= 1'b0;
      rsp_o  <= '0;
      rsp_of <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) state <= EXEC;
        EXEC: begin
          rsp_v  <= 1'b1;
          rsp_id <= id_q;
          rsp_o  <= alu_o;
          rsp_of <= alu_of;
          state  <= RESP;
        end
        RESP: if (rsp_rdy) begin
          rsp_v <= 1'b0;
          state <= accept ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .o  (alu_o),
    .of (alu_of)
  );

`ifdef ALU_ARB_OVF_STICKY_EN
  logic [1:0] ovf_set, ovf_nxt;
  assign ovf_set = (state == EXEC && alu_of) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  // set has priority over a same-edge clear
  assign ovf_nxt = (ovf_clr ? 2'b00 : ovf_stat) | ovf_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_stat <= 2'b00;
      ovf_irq  <= 1'b0;
    end else begin
      ovf_stat <= ovf_nxt;
      ovf_irq  <= |ovf_nxt;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_stat = 2'b00;
  assign ovf_irq  = 1'b0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, corner-case sequences, random vs. model.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_v = 2'b00;
  logic [1:0]   req_rdy;
  logic [2:0]   req_op0 = '0, req_op1 = '0;
  logic [W-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic         rsp_v, rsp_rdy = 1'b0, rsp_id, rsp_of;
  logic [W-1:0] rsp_o;
  logic         ovf_clr = 1'b0;
  logic [1:0]   ovf_stat;
  logic         ovf_irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_v(req_v), .req_rdy(req_rdy),
    .req_op0(req_op0), .req_a0(req_a0), .req_b0(req_b0),
    .req_op1(req_op1), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_v(rsp_v), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_o(rsp_o), .rsp_of(rsp_of),
    .ovf_clr(ovf_clr), .ovf_stat(ovf_stat), .ovf_irq(ovf_irq)
  );

  typedef struct {
    int          r;
    logic [2:0]  op;
    logic [31:0] a, b, exp_o;
    logic        exp_of;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed results computed in 64-bit, overflow when out of 32-bit signed range
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] o, output logic of);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    of = 1'b0;
    case (op)
      3'd0: o = ~a;
      3'd1: o = a & b;
      3'd2: o = a ^ b;
      3'd3: o = a | b;
      default: begin
        case (op)
          3'd4:    s = sa - 1;
          3'd5:    s = sa + sb;
          3'd6:    s = sa - sb;
          default: s = sa + 1;
        endcase
        o  = s[31:0];
        of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
    endcase
  endfunction

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!rsp_v && n < 10) begin
      step();
      n++;
    end
    chk({name, "_rsp_timeout"}, rsp_v, 1);
  endtask

  // Single-requester op: request, accept, wait for response, consume it
  task automatic run_op(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] o, output logic of, output logic id);
    if (r == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; req_v = 2'b01; end
    else        begin req_op1 = op; req_a1 = a; req_b1 = b; req_v = 2'b10; end
    #1;
    chk("grant", req_rdy, (r == 0) ? 2'b01 : 2'b10);
    step();
    req_v = 2'b00;
    chk("exec_no_rsp", rsp_v, 0);
    wait_rsp("op");
    o  = rsp_o;
    of = rsp_of;
    id = rsp_id;
`ifndef ALU_ARB_OVF_STICKY_EN
    chk("ovf_stat_off", ovf_stat, 0);
`endif
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin
    logic [31:0] o, eo, held;
    logic        of, eof, id;
    int          ng, nr, n, seen;
    logic [1:0]  grants[4];
    logic        ids[4];
    logic [31:0] outs[4];

    vecs[0]  = '{0, 3'b101, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1};
    vecs[1]  = '{1, 3'b100, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{1, 3'b111, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0};
    vecs[3]  = '{0, 3'b000, 32'h0F0F0F0F, 32'h0,        32'hF0F0F0F0, 1'b0};
    vecs[4]  = '{1, 3'b001, 32'hF0F0FFFF, 32'h0FF00F0F, 32'h00F00F0F, 1'b0};
    vecs[5]  = '{0, 3'b010, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0};
    vecs[6]  = '{1, 3'b011, 32'h12000034, 32'h00560000, 32'h12560034, 1'b0};
    vecs[7]  = '{0, 3'b110, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1};
    vecs[8]  = '{1, 3'b100, 32'h80000000, 32'h0,        32'h7FFFFFFF, 1'b1};
    vecs[9]  = '{0, 3'b111, 32'h7FFFFFFF, 32'h0,        32'h80000000, 1'b1};
    vecs[10] = '{1, 3'b110, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b0};

    // Reset state
    #3;
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_rsp_v", rsp_v, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_o", rsp_o, 0);
    chk("rst_rsp_of", rsp_of, 0);
    chk("rst_ovf_stat", ovf_stat, 0);
    chk("rst_ovf_irq", ovf_irq, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Fairness: both requesting, response always consumed
    req_op0 = 3'b101; req_a0 = 32'd1;  req_b0 = 32'd2;
    req_op1 = 3'b110; req_a1 = 32'd10; req_b1 = 32'd3;
    req_v = 2'b11;
    rsp_rdy = 1'b1;
    #1;
    chk("first_tie", req_rdy, 2'b01);
    ng = 0; nr = 0; n = 0;
    while ((ng < 4 || nr < 4) && n < 30) begin
      if (req_rdy != 2'b00 && ng < 4) begin grants[ng] = req_rdy; ng++; end
      if (rsp_v && nr < 4) begin ids[nr] = rsp_id; outs[nr] = rsp_o; nr++; end
      step();
      #1;
      if (ng == 4) req_v = 2'b00;
      n++;
    end
    chk("fair_timeout", {ng[15:0], nr[15:0]}, {16'd4, 16'd4});
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fair_grant%0d", k), grants[k], (k % 2 == 1) ? 2'b10 : 2'b01);
      chk($sformatf("fair_id%0d", k), ids[k], (k % 2 == 1) ? 1 : 0);
      chk($sformatf("fair_o%0d", k), outs[k], (k % 2 == 1) ? 32'd7 : 32'd3);
    end
    rsp_rdy = 1'b0;
    step();

    // Vector table
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, o, of, id);
      chk($sformatf("vec%0d_o", i), o, vecs[i].exp_o);
      chk($sformatf("vec%0d_of", i), of, vecs[i].exp_of);
      chk($sformatf("vec%0d_id", i), id, vecs[i].r);
    end

    // Backpressure with a same-cycle handoff to requester 1
    req_op0 = 3'b011; req_a0 = 32'h00FF0000; req_b0 = 32'h000000FF;
    req_v = 2'b01;
    step();
    req_v = 2'b00;
    wait_rsp("bp");
    held = rsp_o;
    chk("bp_o", held, 32'h00FF00FF);
    req_op1 = 3'b101; req_a1 = 32'd40; req_b1 = 32'd2;
    req_v = 2'b10;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (!rsp_v || rsp_o !== held || req_rdy !== 2'b00) seen++;
      step();
    end
    chk("bp_stable", seen, 0);
    rsp_rdy = 1'b1;
    #1;
    chk("bp_handoff", req_rdy, 2'b10);
    step();
    req_v = 2'b00;
    rsp_rdy = 1'b0;
    wait_rsp("bp2");
    chk("bp2_id", rsp_id, 1);
    chk("bp2_o", rsp_o, 32'd42);
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;

`ifdef ALU_ARB_OVF_STICKY_EN
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    step();
    chk("sticky_pre_clr", ovf_stat, 0);
    run_op(1, 3'b101, 32'h7FFFFFFF, 32'h1, o, of, id);
    chk("sticky_of", of, 1);
    step();
    chk("sticky_stat", ovf_stat, 2'b10);
    chk("sticky_irq", ovf_irq, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("sticky_clr", ovf_stat, 0);
    step();
    chk("sticky_irq_clr", ovf_irq, 0);
`endif

    // Reset during EXEC discards the op
    req_op0 = 3'b101; req_a0 = 32'h7FFFFFFF; req_b0 = 32'h1;
    req_v = 2'b01;
    step();
    req_v = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_v", rsp_v, 0);
    chk("midrst_rsp_o", rsp_o, 0);
    chk("midrst_ovf", ovf_stat, 0);
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_v) seen++;
      step();
    end
    chk("midrst_no_rsp", seen, 0);
    req_v = 2'b11;
    #1;
    chk("midrst_tie", req_rdy, 2'b01);
    step();
    req_v = 2'b00;
    wait_rsp("midrst");
    chk("midrst_id", rsp_id, 0);
    chk("midrst_o", rsp_o, 32'h80000000);
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      int          r;
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [31:0] edges[4];
      edges[0] = 32'h0; edges[1] = 32'hFFFFFFFF; edges[2] = 32'h7FFFFFFF; edges[3] = 32'h80000000;
      r  = int'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      model(op, a, b, eo, eof);
      run_op(r, op, a, b, o, of, id);
      chk($sformatf("rnd%0d_o", i), o, eo);
      chk($sformatf("rnd%0d_of", i), of, eof);
      chk($sformatf("rnd%0d_id", i), id, r[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
